// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch stage: issues sequential word fetches to a 1-cycle
// synchronous instruction memory, queues returned words with their PC in a
// small FIFO, and hands them to the core over a valid/ready handshake.
// A redirect flushes the queue and discards the read in flight.
module inst_prefetch_unit #(
    parameter int unsigned      ADDR_W   = 32,
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              res_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_pending;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];

    logic [CW:0]       w_occ;
    logic              w_credit;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_redir_pc;

    // Slots already committed: queued words plus the read whose data returns next cycle.
    // Uses registered count only, so a pop in this cycle does not free a slot yet.
    assign w_occ      = {1'b0, r_count} + {{CW{1'b0}}, r_pending};
    assign w_credit   = (w_occ < (CW+1)'(DEPTH));
    assign w_redir_pc = redirect_pc_i & ~ADDR_W'(3);

    // A redirect overrides both push and pop; the handshake still counts as consumed
    // from the core's side, the flush simply discards everything afterwards.
    assign w_push = r_pending & ~redirect_i;
    assign w_pop  = inst_valid_o & inst_ready_i & ~redirect_i;

    assign mem_addr_o   = r_fetch_pc;
    assign inst_valid_o = (r_count != '0);
    assign inst_o       = r_fifo_data[r_rd_ptr];
    assign inst_pc_o    = r_fifo_pc[r_rd_ptr];

    // FSM state register
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) r_state <= BOOT;
        else        r_state <= w_state_nxt;
    end

    // Next-state and request generation
    always_comb begin
        w_state_nxt = r_state;
        mem_req_o   = 1'b0;
        case (r_state)
            BOOT:  w_state_nxt = FETCH;
            FETCH: begin
                if (w_credit) mem_req_o   = 1'b1;
                else          w_state_nxt = STALL;
            end
            STALL: if (w_credit) w_state_nxt = FETCH;
            default: w_state_nxt = BOOT;
        endcase
        if (redirect_i) w_state_nxt = FETCH;
    end

    // Fetch PC: load redirect target, otherwise advance by one word per request
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i)          r_fetch_pc <= RESET_PC;
        else if (redirect_i) r_fetch_pc <= w_redir_pc;
        else if (mem_req_o)  r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
    end

    // In-flight read tracking; a redirect kills the read issued in the same cycle
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            r_pending <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            r_pending <= mem_req_o & ~redirect_i;
            r_pend_pc <= r_fetch_pc;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (redirect_i) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: returned word together with the PC it was fetched from
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_rdata_i;
            r_fifo_pc[r_wr_ptr]   <= r_pend_pc;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Directed bench for inst_prefetch_unit: a sync-read memory model returns
// address-derived words; expected PCs are queued per step and compared when
// the DUT completes a valid/ready handshake.
module tb_inst_prefetch_unit;

    logic        clk;
    logic        res_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_req = 0;
    logic [31:0] exp_q[$];

    inst_prefetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk_i        (clk),
        .res_i        (res_n),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_valid_o (inst_valid),
        .inst_ready_i (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    // Memory model: synchronous read, data valid the cycle after the address
    always @(posedge clk) mem_rdata <= memf(mem_addr);

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive inputs for the coming edge, then sample away from it; a handshake
    // seen here completes on the next rising edge and is scored now.
    task automatic tick(input logic rdy, input logic rd, input logic [31:0] rpc);
        logic [31:0] e;
        @(negedge clk);
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        if (mem_req) n_req++;
        if (inst_valid && inst_ready) begin
            check("sb_expected_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", inst_pc, e);
                check("sb_inst", inst, memf(e));
            end
        end
    endtask

    task automatic do_reset();
        res_n       = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        #1;
        n_req = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(mem_req), 32'd0);
        check({tag, "_addr"},  mem_addr, 32'h0);
        check({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst"},  inst, 32'h0);
        check({tag, "_pc"},    inst_pc, 32'h0);
    endtask

    initial begin
        res_n       = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        #3;
        check_reset_outputs("rst");

        // Phase 1: streaming with ready=1 from reset, PCs 0,4,.. from C3 without gaps
        do_reset();
        check("c0_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        tick(1'b1, 1'b0, '0);
        check("c1_req", 32'(mem_req), 32'd1);
        check("c1_addr", mem_addr, 32'h0);
        tick(1'b1, 1'b0, '0);
        check("c2_valid", 32'(inst_valid), 32'd0);
        for (int c = 3; c <= 10; c++) begin
            tick(1'b1, 1'b0, '0);
            check("stream_valid", 32'(inst_valid), 32'd1);
        end
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Phase 2: ready=0 fills exactly DEPTH entries, then drains in order
        do_reset();
        repeat (10) tick(1'b0, 1'b0, '0);
        check("full_req_count", 32'(n_req), 32'd4);
        check("full_req_low", 32'(mem_req), 32'd0);
        check("full_valid", 32'(inst_valid), 32'd1);
        check("full_head_pc", inst_pc, 32'h0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        repeat (8) tick(1'b1, 1'b0, '0);
        check("refill_drained", 32'(exp_q.size()), 32'd0);

        // Phase 3: redirect with three words queued
        do_reset();
        repeat (4) tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 32'h0000_0103);
        check("redir_pre_valid", 32'(inst_valid), 32'd1);
        tick(1'b0, 1'b0, '0);
        check("redir_r1_valid", 32'(inst_valid), 32'd0);
        check("redir_r1_req", 32'(mem_req), 32'd1);
        check("redir_r1_addr", mem_addr, 32'h0000_0100);
        tick(1'b0, 1'b0, '0);
        check("redir_r2_valid", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        tick(1'b1, 1'b0, '0);
        check("redir_r3_valid", 32'(inst_valid), 32'd1);
        check("redir_r3_pc", inst_pc, 32'h0000_0100);
        repeat (3) tick(1'b1, 1'b0, '0);
        check("redir_drained", 32'(exp_q.size()), 32'd0);

        // Phase 4: redirect coincident with a completed handshake
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        repeat (3) tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 32'h0000_0200);
        check("coin_head_consumed", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        tick(1'b1, 1'b0, '0);
        check("coin_r1_valid", 32'(inst_valid), 32'd0);
        tick(1'b1, 1'b0, '0);
        check("coin_r2_valid", 32'(inst_valid), 32'd0);
        tick(1'b1, 1'b0, '0);
        check("coin_r3_pc", inst_pc, 32'h0000_0200);
        tick(1'b1, 1'b0, '0);
        check("coin_drained", 32'(exp_q.size()), 32'd0);

        // Phase 5: address wrap at the top of the space; request killed at C1
        do_reset();
        tick(1'b1, 1'b1, 32'hFFFF_FFFE);
        check("wrap_killed_addr", mem_addr, 32'h0);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        tick(1'b1, 1'b0, '0);
        check("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, '0);
        check("wrap_addr_zero", mem_addr, 32'h0000_0000);
        check("wrap_req", 32'(mem_req), 32'd1);
        repeat (3) tick(1'b1, 1'b0, '0);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

        // Phase 6: async reset mid-stream with a read in flight
        tick(1'b0, 1'b0, '0);
        check("mid_inflight", 32'(mem_req), 32'd1);
        #1 res_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(4 * i));
        tick(1'b1, 1'b0, '0);
        check("restart_addr", mem_addr, 32'h0);
        repeat (4) tick(1'b1, 1'b0, '0);
        check("restart_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
